// File: rtl/dmux8way16_buf_pkg.sv
// Shared constants and channel-state encoding for the buffered 1-to-8 demultiplexer.
// Guarded so that several files can include or compile it without redefinition.
`ifndef DMUX8WAY16_BUF_PKG_SV
`define DMUX8WAY16_BUF_PKG_SV

package dmux8way16_buf_pkg;

    localparam int DMUX_WIDTH = 16;
    localparam int DMUX_WAYS  = 8;
    localparam int DMUX_SEL_W = 3;
    localparam int DMUX_CNT_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

`endif

// File: rtl/dmux8way16_buf_slot.sv
// dmux_slot: one-entry output register for a single demux channel.
// Holds one word with a valid flag; a same-cycle load and drain keeps the slot full.
module dmux_slot
    import dmux8way16_buf_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_e      r_state;
    slot_state_e      w_next_state;
    logic [WIDTH-1:0] r_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: a load always wins over a drain, so back-to-back words never bubble
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_load) w_next_state = SLOT_FULL;
                else        w_next_state = SLOT_EMPTY;
            end
            SLOT_FULL: begin
                if (i_drain && !i_load) w_next_state = SLOT_EMPTY;
                else                    w_next_state = SLOT_FULL;
            end
            default: w_next_state = SLOT_EMPTY;
        endcase
    end

    // Output decode
    always_comb begin
        o_valid = 1'b0;
        if (r_state == SLOT_FULL) o_valid = 1'b1;
        else                      o_valid = 1'b0;
    end

    // Data register: only a load changes it, so an empty slot keeps its last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/dmux8way16_buf.sv
// Buffered 1-to-8 demultiplexer: routes each accepted word to the channel picked by sel,
// where it waits in a one-entry slot until that channel's consumer takes it.
module dmux8way16_buf
    import dmux8way16_buf_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH,
    parameter int WAYS  = DMUX_WAYS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [DMUX_SEL_W-1:0] sel,
    output logic [WAYS-1:0]       out_valid,
    input  logic [WAYS-1:0]       out_ready,
    output logic [WAYS*WIDTH-1:0] out_data,
    output logic [DMUX_CNT_W-1:0] xfer_count
);

    logic                  w_in_ready;
    logic                  w_in_xfer;
    logic [WAYS-1:0]       w_load;
    logic [WAYS-1:0]       w_slot_valid;
    logic [DMUX_CNT_W-1:0] r_xfer_count;

    // Only the addressed channel gates acceptance; other channels may stall freely
    assign w_in_ready = ~w_slot_valid[sel] | out_ready[sel];
    assign w_in_xfer  = in_valid & w_in_ready;

    // One-hot load strobe for the addressed slot
    always_comb begin
        w_load = {WAYS{1'b0}};
        if (w_in_xfer) begin
            w_load[sel] = 1'b1;
        end else begin
            w_load = {WAYS{1'b0}};
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_slot
        dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_drain (out_ready[g]),
            .i_data  (in_data),
            .o_valid (w_slot_valid[g]),
            .o_data  (out_data[WIDTH*g +: WIDTH])
        );
    end

    // Accepted-word counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= {DMUX_CNT_W{1'b0}};
        end else if (w_in_xfer) begin
            r_xfer_count <= r_xfer_count + {{(DMUX_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_xfer_count <= r_xfer_count;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_slot_valid;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: directed scenarios plus random traffic
// compared against a per-channel "held word" model.
module tb_dmux8way16_buf;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic [2:0]   sel;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [127:0] out_data;
    logic [15:0]  xfer_count;

    int n_checks;
    int n_errors;

    // Reference model: what each channel currently holds and how many words were taken
    bit          m_full [8];
    logic [15:0] m_word [8];
    int unsigned m_taken;

    dmux8way16_buf #(.WIDTH(16), .WAYS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic logic [127:0] exp_data();
        logic [127:0] d;
        for (int k = 0; k < 8; k++) d[k*16 +: 16] = m_word[k];
        return d;
    endfunction

    function automatic logic exp_ready();
        return !m_full[sel] || out_ready[sel];
    endfunction

    function automatic logic [15:0] exp_count();
        return 16'(m_taken % 65536);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_word[k] = 16'h0000;
        end
        m_taken = 0;
    endtask

    task automatic apply(input logic iv, input logic [2:0] s, input logic [15:0] d,
                         input logic [7:0] ordy);
        in_valid  = iv;
        sel       = s;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Advance one clock: the consumer takes held words, then the accepted word lands
    task automatic edge_step();
        bit       take;
        logic [2:0]  s;
        logic [15:0] d;
        take = in_valid && exp_ready();
        s = sel;
        d = in_data;
        @(posedge clk);
        for (int k = 0; k < 8; k++)
            if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
        if (take) begin
            m_full[s] = 1'b1;
            m_word[s] = d;
            m_taken++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(1'b1, 3'd1, 16'h1111, 8'h00);
        model_clear();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_errors++; $display("FAIL reset_out_valid: got %h want 00", out_valid);
        end
        n_checks++;
        if (out_data !== 128'h0) begin
            n_errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        n_checks++;
        if (xfer_count !== 16'h0000) begin
            n_errors++; $display("FAIL reset_count: got %h want 0000", xfer_count);
        end
        apply(1'b0, 3'd0, 16'h0000, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply(1'b1, 3'd5, 16'hBEEF, 8'h00);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        edge_step();
        apply(1'b0, 3'd0, 16'h0000, 8'h00);
        n_checks++;
        if (out_valid !== 8'b0010_0000) begin
            n_errors++; $display("FAIL single_out_valid: got %b want 00100000", out_valid);
        end
        n_checks++;
        if (out_data[5*16 +: 16] !== 16'hBEEF) begin
            n_errors++; $display("FAIL single_slice5: got %h want beef", out_data[5*16 +: 16]);
        end
        n_checks++;
        if (xfer_count !== 16'h0001) begin
            n_errors++; $display("FAIL single_count: got %h want 0001", xfer_count);
        end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        apply(1'b0, 3'd0, 16'h0000, 8'hFF);
        edge_step();
        apply(1'b1, 3'd2, 16'h0C0C, 8'h00);
        edge_step();
        held = m_word[2];
        apply(1'b1, 3'd2, 16'h1234, 8'h00);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        edge_step();
        n_checks++;
        if (out_data[2*16 +: 16] !== held) begin
            n_errors++; $display("FAIL stall_slice2: got %h want %h", out_data[2*16 +: 16], held);
        end
        apply(1'b1, 3'd3, 16'h3333, 8'h00);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL stall_other_ready: got %b want 1", in_ready);
        end
        edge_step();
        n_checks++;
        if (out_valid !== 8'b0000_1100) begin
            n_errors++; $display("FAIL stall_out_valid: got %b want 00001100", out_valid);
        end
    endtask

    task automatic test_same_cycle();
        apply(1'b1, 3'd7, 16'hAAAA, 8'h00);
        edge_step();
        apply(1'b1, 3'd7, 16'h5555, 8'h80);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL same_in_ready: got %b want 1", in_ready);
        end
        edge_step();
        apply(1'b0, 3'd0, 16'h0000, 8'h00);
        n_checks++;
        if (out_valid[7] !== 1'b1) begin
            n_errors++; $display("FAIL same_valid7: got %b want 1", out_valid[7]);
        end
        n_checks++;
        if (out_data[7*16 +: 16] !== 16'h5555) begin
            n_errors++; $display("FAIL same_slice7: got %h want 5555", out_data[7*16 +: 16]);
        end
    endtask

    task automatic test_drain();
        apply(1'b1, 3'd0, 16'h0F0F, 8'h00);
        edge_step();
        apply(1'b0, 3'd0, 16'h0000, 8'h01);
        edge_step();
        n_checks++;
        if (out_valid[0] !== 1'b0) begin
            n_errors++; $display("FAIL drain_valid0: got %b want 0", out_valid[0]);
        end
        n_checks++;
        if (out_valid !== exp_valid()) begin
            n_errors++; $display("FAIL drain_out_valid: got %b want %b", out_valid, exp_valid());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  8'($urandom) & 8'($urandom));
            n_checks++;
            if (in_ready !== exp_ready()) begin
                n_errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            end
            edge_step();
            n_checks++;
            if (out_valid !== exp_valid()) begin
                n_errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", i, out_valid, exp_valid());
            end
            n_checks++;
            if (out_data !== exp_data()) begin
                n_errors++; $display("FAIL rand_out_data[%0d]: got %h want %h", i, out_data, exp_data());
            end
            n_checks++;
            if (xfer_count !== exp_count()) begin
                n_errors++; $display("FAIL rand_count[%0d]: got %h want %h", i, xfer_count, exp_count());
            end
        end
    endtask

    task automatic test_async_reset();
        apply(1'b0, 3'd0, 16'h0000, 8'hFF);
        edge_step();
        apply(1'b1, 3'd1, 16'h1001, 8'h00);
        edge_step();
        apply(1'b1, 3'd4, 16'h4004, 8'h00);
        edge_step();
        apply(1'b1, 3'd6, 16'h6006, 8'h00);
        edge_step();
        apply(1'b0, 3'd0, 16'h0000, 8'h00);
        n_checks++;
        if (out_valid !== 8'b0101_0010) begin
            n_errors++; $display("FAIL arst_pre_valid: got %b want 01010010", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_errors++; $display("FAIL arst_valid: got %b want 00000000", out_valid);
        end
        n_checks++;
        if (out_data !== 128'h0) begin
            n_errors++; $display("FAIL arst_data: got %h want 0", out_data);
        end
        n_checks++;
        if (xfer_count !== 16'h0000) begin
            n_errors++; $display("FAIL arst_count: got %h want 0000", xfer_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL arst_in_ready: got %b want 1", in_ready);
        end
        model_clear();
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 65535; i++) begin
            apply(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 8'hFF);
            edge_step();
        end
        apply(1'b0, 3'd0, 16'h0000, 8'hFF);
        n_checks++;
        if (xfer_count !== 16'hFFFF) begin
            n_errors++; $display("FAIL wrap_preload: got %h want ffff", xfer_count);
        end
        n_checks++;
        if (out_data !== exp_data()) begin
            n_errors++; $display("FAIL wrap_data: got %h want %h", out_data, exp_data());
        end
        apply(1'b1, 3'd2, 16'h2222, 8'hFF);
        edge_step();
        n_checks++;
        if (xfer_count !== 16'h0000) begin
            n_errors++; $display("FAIL wrap_count: got %h want 0000", xfer_count);
        end
        n_checks++;
        if (out_valid !== 8'b0000_0100) begin
            n_errors++; $display("FAIL wrap_valid: got %b want 00000100", out_valid);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        sel       = 3'd0;
        out_ready = 8'h00;
        #2;
        test_reset();
        test_single();
        test_stall();
        test_same_cycle();
        test_drain();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
